// File: rtl/noc_pkg.sv
// Shared ring-router definitions: flit width, arbiter state encoding and
// the port indices used by every output-port arbiter.
package noc_pkg;

  localparam int FLIT_WIDTH = 64;

  typedef enum logic {
    IDLE    = 1'b0,
    FORWARD = 1'b1
  } arb_state_e;

  localparam int PORT_CW  = 0;
  localparam int PORT_CCW = 1;
  localparam int PORT_PE  = 2;

endpackage

// File: rtl/ring_port_arbiter_rr_pick.sv
// Combinational round-robin selector: the first eligible requester found
// when searching upward from ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] winner_o
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [IDX_W-1:0] idx_at [N];

  // idx_at[k] is the requester k places after the pointer, wrapped once.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum        = {1'b0, ptr_i} + (IDX_W + 1)'(gi);
    assign idx_at[gi] = (sum >= N_W) ? IDX_W'(sum - N_W) : sum[IDX_W-1:0];
  end

  // Scanning from the far end lets the nearest eligible candidate win.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig_i[idx_at[k]]) begin
        found_o  = 1'b1;
        winner_o = idx_at[k];
      end
    end
  end

endmodule

// File: rtl/ring_port_arbiter.sv
// Round-robin arbiter sharing one downstream single-entry buffer among
// NUM_REQ upstream buffers; fetch in one cycle, write the next.
module ring_port_arbiter
  import noc_pkg::*;
#(
  parameter  int WIDTH   = FLIT_WIDTH,
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       reqEmpty,
  input  logic [NUM_REQ*WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]       reqRdEnable,
  input  logic                     outFull,
  output logic                     outWrEnable,
  output logic [WIDTH-1:0]         outData,
  output logic                     busy
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

  logic [WIDTH-1:0] req_slice [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic             found;
  logic [IDX_W-1:0] winner;
  logic             wr_fire;
  logic             issue;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_slice[gi] = reqData[gi*WIDTH +: WIDTH];
  end

  assign elig = ~reqEmpty;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig_i   (elig),
    .ptr_i    (rr_ptr_q),
    .found_o  (found),
    .winner_o (winner)
  );

  // Reset suppresses both handshakes so no upstream flit is consumed and
  // nothing reaches the downstream buffer while state is being cleared.
  assign wr_fire = (state_q == FORWARD) && !outFull && !reset;
  assign issue   = found && !reset &&
                   (((state_q == IDLE) && !outFull) || wr_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    if (issue) begin
      state_d     = FORWARD;
      grant_idx_d = winner;
      rr_ptr_d    = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (wr_fire) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    reqRdEnable = '0;
    if (issue) begin
      reqRdEnable[winner] = 1'b1;
    end
    outWrEnable = wr_fire;
    busy        = (state_q == FORWARD);
    outData     = (state_q == FORWARD) ? req_slice[grant_idx_q] : '0;
  end

endmodule

// File: tb/tb_ring_port_arbiter.sv
// Directed bench for ring_port_arbiter: stimulus queues expected grants and
// writes, a negedge monitor pops and compares them as the DUT produces them.
module tb_ring_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst3, rst5, of3, of5;
  logic [63:0]  mem3 [3];
  logic [63:0]  dout3 [3];
  logic [63:0]  mem5 [5];
  logic [63:0]  dout5 [5];
  logic [2:0]   full3, empty3, rd3;
  logic [4:0]   full5, empty5, rd5;
  logic [191:0] data3;
  logic [319:0] data5;
  logic         wr3, busy3, wr5, busy5;
  logic [63:0]  od3, od5;

  assign empty3 = ~full3;
  assign empty5 = ~full5;
  for (genvar gi = 0; gi < 3; gi++) begin : g_d3
    assign data3[gi*64 +: 64] = dout3[gi];
  end
  for (genvar gi = 0; gi < 5; gi++) begin : g_d5
    assign data5[gi*64 +: 64] = dout5[gi];
  end

  ring_port_arbiter #(.WIDTH(64), .NUM_REQ(3)) dut3 (
    .clk(clk), .reset(rst3), .reqEmpty(empty3), .reqData(data3),
    .reqRdEnable(rd3), .outFull(of3), .outWrEnable(wr3), .outData(od3),
    .busy(busy3)
  );

  ring_port_arbiter #(.WIDTH(64), .NUM_REQ(5)) dut5 (
    .clk(clk), .reset(rst5), .reqEmpty(empty5), .reqData(data5),
    .reqRdEnable(rd5), .outFull(of5), .outWrEnable(wr5), .outData(od5),
    .busy(busy5)
  );

  int          g3_q[$], g5_q[$];
  logic [63:0] w3_q[$], w5_q[$];

  logic        p_en, p_busy, p_wr, done;
  logic [63:0] p_data;
  string       p_name;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    cyc++;
    if (rd3 != 3'b000) begin
      check("rd3_legal", 64'(($onehot(rd3) && ((rd3 & empty3) == 3'b000)) ? 1 : 0), 64'd1);
      if (g3_q.size() == 0) check("rd3_unexpected", 64'(rd3), 64'd0);
      else check("rd3_grant", 64'(rd3), 64'(3'b001 << g3_q.pop_front()));
    end
    if (wr3) begin
      if (w3_q.size() == 0) check("wr3_unexpected", od3, 64'hDEAD);
      else check("wr3_data", od3, w3_q.pop_front());
    end
    if (rd5 != 5'b00000) begin
      check("rd5_legal", 64'(($onehot(rd5) && ((rd5 & empty5) == 5'b00000)) ? 1 : 0), 64'd1);
      if (g5_q.size() == 0) check("rd5_unexpected", 64'(rd5), 64'd0);
      else check("rd5_grant", 64'(rd5), 64'(5'b00001 << g5_q.pop_front()));
    end
    if (wr5) begin
      if (w5_q.size() == 0) check("wr5_unexpected", od5, 64'hDEAD);
      else check("wr5_data", od5, w5_q.pop_front());
    end
    if (p_en) begin
      check({p_name, "_busy"}, 64'(busy3), 64'(p_busy));
      check({p_name, "_wr"}, 64'(wr3), 64'(p_wr));
      check({p_name, "_data"}, od3, p_data);
    end
    if (done || cyc > 5000) begin
      check("timeout", 64'(done), 64'd1);
      check("g3_left", 64'(g3_q.size()), 64'd0);
      check("w3_left", 64'(w3_q.size()), 64'd0);
      check("g5_left", 64'(g5_q.size()), 64'd0);
      check("w5_left", 64'(w5_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic load3(input int i, input logic [63:0] d);
    mem3[i] = d; full3[i] = 1'b1;
  endtask

  task automatic load5(input int i, input logic [63:0] d);
    mem5[i] = d; full5[i] = 1'b1;
  endtask

  task automatic probe(input string n, input logic b, input logic w, input logic [63:0] d);
    p_name = n; p_busy = b; p_wr = w; p_data = d; p_en = 1'b1;
  endtask

  // One cycle; upstream buffers follow the sampled rdEnable (one-cycle read).
  task automatic tick();
    logic [2:0] r3;
    logic [4:0] r5;
    @(negedge clk);
    r3 = rd3; r5 = rd5;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (r3[i]) begin dout3[i] = mem3[i]; full3[i] = 1'b0; end
    for (int i = 0; i < 5; i++) if (r5[i]) begin dout5[i] = mem5[i]; full5[i] = 1'b0; end
    p_en = 1'b0;
  endtask

  initial begin
    rst3 = 1'b1; rst5 = 1'b1; of3 = 1'b0; of5 = 1'b0;
    full3 = '0; full5 = '0; p_en = 1'b0; done = 1'b0;
    p_busy = 1'b0; p_wr = 1'b0; p_data = '0; p_name = "";
    for (int i = 0; i < 3; i++) begin mem3[i] = '0; dout3[i] = '0; end
    for (int i = 0; i < 5; i++) begin mem5[i] = '0; dout5[i] = '0; end
    @(posedge clk); #1;
    tick();
    probe("reset", 1'b0, 1'b0, 64'h0); tick();
    rst3 = 1'b0;

    // Single request: rd at T, write at T+1, idle at T+2.
    load3(0, 64'hA5A5); g3_q.push_back(0); w3_q.push_back(64'hA5A5);
    probe("s1_t0", 1'b0, 1'b0, 64'h0); tick();
    probe("s1_t1", 1'b1, 1'b1, 64'hA5A5); tick();
    probe("s1_t2", 1'b0, 1'b0, 64'h0); tick();

    // All three requesting from rrPtr=0: order 0,1,2,0, back-to-back writes.
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    load3(0, 64'h100); load3(1, 64'h101); load3(2, 64'h102);
    g3_q.push_back(0); g3_q.push_back(1); g3_q.push_back(2); g3_q.push_back(0);
    w3_q.push_back(64'h100); w3_q.push_back(64'h101);
    w3_q.push_back(64'h102); w3_q.push_back(64'h103);
    probe("rr_c0", 1'b0, 1'b0, 64'h0); tick();
    load3(0, 64'h103);
    probe("rr_c1", 1'b1, 1'b1, 64'h100); tick();
    probe("rr_c2", 1'b1, 1'b1, 64'h101); tick();
    probe("rr_c3", 1'b1, 1'b1, 64'h102); tick();
    probe("rr_c4", 1'b1, 1'b1, 64'h103); tick();
    probe("rr_c5", 1'b0, 1'b0, 64'h0); tick();

    // Backpressure on a fetched flit from requester 1 (rrPtr=1).
    load3(1, 64'h1234); g3_q.push_back(1); w3_q.push_back(64'h1234); tick();
    of3 = 1'b1; load3(0, 64'h55); g3_q.push_back(0); w3_q.push_back(64'h55);
    for (int k = 0; k < 4; k++) begin probe("bp_hold", 1'b1, 1'b0, 64'h1234); tick(); end
    of3 = 1'b0;
    probe("bp_release", 1'b1, 1'b1, 64'h1234); tick();
    probe("bp_next", 1'b1, 1'b1, 64'h55); tick();
    probe("bp_idle", 1'b0, 1'b0, 64'h0); tick();

    // IDLE with outFull=1 and all requesting: first grant at rrPtr=1.
    of3 = 1'b1;
    load3(0, 64'h200); load3(1, 64'h201); load3(2, 64'h202);
    g3_q.push_back(1); g3_q.push_back(2); g3_q.push_back(0);
    w3_q.push_back(64'h201); w3_q.push_back(64'h202); w3_q.push_back(64'h200);
    for (int k = 0; k < 3; k++) begin probe("full_idle", 1'b0, 1'b0, 64'h0); tick(); end
    of3 = 1'b0;
    probe("full_rel", 1'b0, 1'b0, 64'h0); tick();
    probe("drain_1", 1'b1, 1'b1, 64'h201); tick();
    probe("drain_2", 1'b1, 1'b1, 64'h202); tick();
    probe("drain_0", 1'b1, 1'b1, 64'h200); tick();
    probe("drain_idle", 1'b0, 1'b0, 64'h0); tick();

    // Reset while forwarding: flit 0x77 is dropped, then requester 2 regranted.
    load3(2, 64'h77); g3_q.push_back(2);
    probe("rst_c0", 1'b0, 1'b0, 64'h0); tick();
    rst3 = 1'b1; load3(2, 64'hAA); tick();
    probe("rst_out", 1'b0, 1'b0, 64'h0); tick();
    rst3 = 1'b0; g3_q.push_back(2); w3_q.push_back(64'hAA);
    probe("rst_regrant", 1'b0, 1'b0, 64'h0); tick();
    probe("rst_wr", 1'b1, 1'b1, 64'hAA); tick();
    probe("rst_idle", 1'b0, 1'b0, 64'h0); tick();

    // NUM_REQ=5 with requesters 4 and 0 alternating.
    rst5 = 1'b0;
    load5(4, 64'h400);
    g5_q.push_back(4); g5_q.push_back(0); g5_q.push_back(4); g5_q.push_back(0);
    w5_q.push_back(64'h400); w5_q.push_back(64'h500);
    w5_q.push_back(64'h401); w5_q.push_back(64'h501);
    tick();
    load5(0, 64'h500); load5(4, 64'h401); tick();
    load5(0, 64'h501); tick();
    tick(); tick(); tick();
    done = 1'b1;
  end

endmodule
